// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
//   dmem_state_t : responder FSM states (IDLE / WAIT / DONE)
//   WORD_BYTES   : bytes per RAM word (byte address -> word index shift)
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } dmem_state_t;

  localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/dmem_array.sv
// Word-addressed data RAM: combinational read, synchronous write, no reset.
//   clk_i   : rising-edge clock
//   we_i    : write enable
//   waddr_i : write word index
//   wdata_i : write data
//   raddr_i : read word index
//   rdata_o : read data (combinational)
module dmem_array #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 64
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [DATA_W-1:0]        wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [DATA_W-1:0]        rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/dmem_responder.sv
// Responder end of the pipeline's data-memory port. Accepts the M-stage
// access, spends a fixed LATENCY of stall cycles, then a one-cycle DONE.
//   clk       : rising-edge clock
//   reset     : asynchronous, active-low
//   MemReadM  : load request (held by pipeline while stalled)
//   MemWriteM : store request (held by pipeline while stalled)
//   ALUOutM   : byte address
//   WriteData : store data
//   ReadData  : load data, valid in DONE, held until next load completes
//   MemStallM : hold pipeline
//   MemDoneM  : one-cycle pulse in DONE
//   MemErrM   : sticky error of the last accepted request
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemReadM,
  input  logic              MemWriteM,
  input  logic [ADDR_W-1:0] ALUOutM,
  input  logic [DATA_W-1:0] WriteData,
  output logic [DATA_W-1:0] ReadData,
  output logic              MemStallM,
  output logic              MemDoneM,
  output logic              MemErrM
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(LATENCY + 1);
  localparam logic [CNT_W-1:0]  CNT_INIT   = CNT_W'((LATENCY >= 2) ? (LATENCY - 2) : 0);
  localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(WORD_BYTES * DEPTH);

  dmem_state_t       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              load_q, load_d;
  logic              commit_q, commit_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              req;
  logic              addr_bad;
  logic              req_err;
  logic [IDX_W-1:0]  req_idx;
  logic [IDX_W-1:0]  cur_idx;
  logic              cur_load;
  logic              cur_err;
  logic              ram_we;
  logic [DATA_W-1:0] ram_rdata;

  assign req      = MemReadM | MemWriteM;
  assign addr_bad = (ALUOutM[1:0] != 2'b00) || (ALUOutM >= ADDR_LIMIT);
  assign req_err  = addr_bad | (MemReadM & MemWriteM);
  assign req_idx  = ALUOutM[IDX_W+1:2];

  // With LATENCY==1 DONE is entered straight from IDLE, before the request
  // is latched, so the read path must look at the live inputs in IDLE.
  assign cur_idx  = (state_q == IDLE) ? req_idx : addr_q;
  assign cur_load = (state_q == IDLE) ? (MemReadM & ~MemWriteM) : load_q;
  assign cur_err  = (state_q == IDLE) ? req_err : err_q;

  dmem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk_i   (clk),
    .we_i    (ram_we),
    .waddr_i (addr_q),
    .wdata_i (wdata_q),
    .raddr_i (cur_idx),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      load_q   <= 1'b0;
      commit_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      load_q   <= load_d;
      commit_q <= commit_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    load_d   = load_q;
    commit_d = commit_q;
    err_d    = err_q;
    rdata_d  = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          addr_d   = req_idx;
          wdata_d  = WriteData;
          load_d   = MemReadM & ~MemWriteM;
          // read+write is an error but still a store; only bad addresses drop it
          commit_d = MemWriteM & ~addr_bad;
          err_d    = req_err;
          cnt_d    = CNT_INIT;
          state_d  = (LATENCY == 1) ? DONE : WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if ((state_d == DONE) && (state_q != DONE) && cur_load) begin
      rdata_d = cur_err ? '0 : ram_rdata;
    end
  end

  always_comb begin
    // gated by reset so the stall releases the instant reset asserts
    MemStallM = reset & (((state_q == IDLE) & req) | (state_q == WAIT));
    MemDoneM  = (state_q == DONE);
    ram_we    = (state_q == DONE) & commit_q;
  end

  assign ReadData = rdata_q;
  assign MemErrM  = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder. Two instances share the
// request inputs (LATENCY=2 and LATENCY=1); the idle one is held in reset.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst0_n, rst1_n;
  logic        rd, wr;
  logic [31:0] addr, wd;
  logic [31:0] rdata0, rdata1;
  logic        stall0, stall1, done0, done1, err0, err1;

  logic [31:0] o_rdata;
  logic        o_stall, o_done, o_err;

  int          sel;
  logic [31:0] mem_m   [2][64];
  logic [31:0] rd_hold [2];
  logic        last_err[2];
  int          n_cmp, n_bad;

  always #5 clk = ~clk;

  dmem_responder #(.DATA_W(32), .ADDR_W(32), .DEPTH(64), .LATENCY(2)) u_dut_l2 (
    .clk(clk), .reset(rst0_n), .MemReadM(rd), .MemWriteM(wr), .ALUOutM(addr),
    .WriteData(wd), .ReadData(rdata0), .MemStallM(stall0), .MemDoneM(done0), .MemErrM(err0)
  );

  dmem_responder #(.DATA_W(32), .ADDR_W(32), .DEPTH(64), .LATENCY(1)) u_dut_l1 (
    .clk(clk), .reset(rst1_n), .MemReadM(rd), .MemWriteM(wr), .ALUOutM(addr),
    .WriteData(wd), .ReadData(rdata1), .MemStallM(stall1), .MemDoneM(done1), .MemErrM(err1)
  );

  always_comb begin
    if (sel == 0) begin
      o_rdata = rdata0; o_stall = stall0; o_done = done0; o_err = err0;
    end else begin
      o_rdata = rdata1; o_stall = stall1; o_done = done1; o_err = err1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One full access: drive request, expect LATENCY stall cycles then DONE.
  task automatic access(input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input bit mutate);
    int          lat    = (sel == 0) ? 2 : 1;
    logic [5:0]  idx    = a[7:2];
    bit          abad   = (a[1:0] != 2'b00) || (a >= 32'd256);
    bit          err    = abad || (r && w);
    @(posedge clk); #1;
    rd = r; wr = w; addr = a; wd = d;
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      check("stall_hi", 32'(o_stall), 32'd1);
      check("done_lo", 32'(o_done), 32'd0);
      if (mutate && i == 0 && lat > 1) begin
        @(posedge clk); #1;
        wd   = d ^ 32'h3;
        addr = a ^ 32'h4;
      end
    end
    if (!w) rd_hold[sel] = err ? 32'd0 : mem_m[sel][idx];
    last_err[sel] = err;
    @(negedge clk);
    check("done_stall", 32'(o_stall), 32'd0);
    check("done_pulse", 32'(o_done), 32'd1);
    check("done_err", 32'(o_err), 32'(err));
    check("done_rdata", o_rdata, rd_hold[sel]);
    if (w && !abad) mem_m[sel][idx] = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      rd = 1'b0; wr = 1'b0;
      @(negedge clk);
      check("idle_stall", 32'(o_stall), 32'd0);
      check("idle_done", 32'(o_done), 32'd0);
      check("idle_err", 32'(o_err), 32'(last_err[sel]));
      check("idle_rdata", o_rdata, rd_hold[sel]);
    end
  endtask

  initial begin
    logic [31:0] a;
    logic        r, w;
    int          c;
    n_cmp = 0; n_bad = 0; sel = 0;
    rd = 1'b0; wr = 1'b0; addr = '0; wd = '0;
    rst0_n = 1'b0; rst1_n = 1'b0;
    for (int s = 0; s < 2; s++) begin
      rd_hold[s] = '0; last_err[s] = 1'b0;
    end
    #23;
    check("rst_stall", 32'(o_stall), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);
    check("rst_err", 32'(o_err), 32'd0);
    check("rst_rdata", o_rdata, 32'd0);
    rst0_n = 1'b1;

    // directed: store/load, error cases, ignored mid-access input changes
    access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
    idle(1);
    access(1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
    idle(3);
    access(1'b1, 1'b0, 32'h13, 32'h0, 1'b0);
    access(1'b1, 1'b0, 32'h100, 32'h0, 1'b0);
    idle(1);
    access(1'b0, 1'b1, 32'h12, 32'h00000BAD, 1'b0);
    access(1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
    access(1'b0, 1'b1, 32'h20, 32'h1, 1'b1);
    access(1'b1, 1'b0, 32'h20, 32'h0, 1'b0);
    idle(1);

    for (int i = 0; i < 64; i++) access(1'b0, 1'b1, 32'(i * 4), $urandom, 1'b0);
    access(1'b1, 1'b0, 32'h8, 32'h0, 1'b0);

    // reset in the middle of a store's WAIT
    @(posedge clk); #1;
    rd = 1'b0; wr = 1'b1; addr = 32'h8; wd = 32'h55;
    @(negedge clk);
    check("rstw_stall_hi", 32'(o_stall), 32'd1);
    @(posedge clk); #2;
    rst0_n = 1'b0; rd = 1'b0; wr = 1'b0;
    #1;
    check("rstw_stall", 32'(o_stall), 32'd0);
    check("rstw_rdata", o_rdata, 32'd0);
    check("rstw_err", 32'(o_err), 32'd0);
    rd_hold[0] = '0; last_err[0] = 1'b0;
    @(negedge clk);
    rst0_n = 1'b1;
    idle(2);
    access(1'b1, 1'b0, 32'h8, 32'h0, 1'b0);

    // randomized mix against the reference model
    for (int k = 0; k < 150; k++) begin
      c = $urandom_range(0, 99);
      r = 1'b0; w = 1'b0;
      if (c < 75) begin
        a = 32'($urandom_range(0, 63) * 4);
        w = 1'($urandom_range(0, 1)); r = ~w;
      end else if (c < 83) begin
        a = 32'($urandom_range(0, 63) * 4) | 32'($urandom_range(1, 3));
        w = 1'($urandom_range(0, 1)); r = ~w;
      end else if (c < 91) begin
        a = ($urandom | 32'h100) & ~32'h3;
        w = 1'($urandom_range(0, 1)); r = ~w;
      end else begin
        a = 32'($urandom_range(0, 63) * 4);
        r = 1'b1; w = 1'b1;
      end
      access(r, w, a, $urandom, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) idle(1);
    end

    // LATENCY=1 instance: back-to-back store then load of the same word
    @(posedge clk); #1;
    rd = 1'b0; wr = 1'b0;
    rst0_n = 1'b0; sel = 1;
    #1;
    check("l1_rst_rdata", o_rdata, 32'd0);
    check("l1_rst_stall", 32'(o_stall), 32'd0);
    @(negedge clk);
    rst1_n = 1'b1;
    idle(1);
    for (int k = 0; k < 20; k++) begin
      a = 32'($urandom_range(0, 63) * 4);
      access(1'b0, 1'b1, a, $urandom, 1'b0);
      access(1'b1, 1'b0, a, 32'h0, 1'b0);
      if (k % 4 == 0) idle(1);
    end
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
